lc3_regfile: RTL and testbench
==============================

// Module: lc3_regfile
// PURPOSE
//   LC-3 general-purpose register file and condition-code unit. Sits directly upstream
//   of the ALU and supplies its two operands: op_a = R[SR1], and op_b = R[SR2] or
//   SEXT(imm5). Captures writeback from the processor bus into R[DR], sets the NZP
//   condition codes, and registers the branch-enable (BEN) flag for the control FSM.
// PARAMETERS
//   DATA_W   16  datapath width; the LC-3 ISA fixes this at 16.
//   NREG     8   number of general-purpose registers, R0..R7.
//   ADDR_W   3   register-address width; must equal clog2(NREG).
//   BYPASS   1   1 = a same-cycle write is forwarded to the read ports; 0 = reads return the stored value.
// PORTS
//   clk        in   1       single clock; all state updates on its rising edge.
//   rst_n      in   1       synchronous reset, active low.
//   sr1_addr   in   3       SR1 select (IR[8:6]).
//   sr2_addr   in   3       SR2 select (IR[2:0]).
//   imm5       in   5       immediate field (IR[4:0]).
//   sr2mux_sel in   1       1: op_b = SEXT(imm5); 0: op_b = R[sr2_addr].
//   op_a       out  16      ALU operand A (combinational).
//   op_b       out  16      ALU operand B (combinational).
//   dr_addr    in   3       destination register (IR[11:9], or 7 for JSR/TRAP).
//   ld_reg     in   1       write-enable for R[dr_addr].
//   bus_in     in   16      processor bus value; source of register and CC writes.
//   ld_cc      in   1       load NZP from bus_in.
//   br_nzp     in   3       branch mask (IR[11:9]).
//   ld_ben     in   1       load BEN.
//   cc_nzp     out  3       registered condition codes {N,Z,P}.
//   ben        out  1       registered branch enable.
// BEHAVIOUR
//   Reset (rst_n low at a clk edge): R0..R7 <= 0; cc_nzp <= 3'b010; ben <= 0.
//     - rst_n dominates ld_reg, ld_cc and ld_ben in the same cycle.
//     - op_a and op_b follow the reset register values from the next cycle onward.
//   Reads: pure combinational, zero latency.
//     - op_a = R[sr1_addr].
//     - op_b = sr2mux_sel ? {{11{imm5[4]}},imm5} : R[sr2_addr].
//   Write: if ld_reg, R[dr_addr] <= bus_in at the edge. No other register changes.
//     - R0 is an ordinary writable register (not hardwired to zero).
//   Bypass (BYPASS=1): while ld_reg=1 and dr_addr==sr1_addr, op_a = bus_in.
//     - The same rule applies to op_b when sr2mux_sel=0 and dr_addr==sr2_addr.
//     - With BYPASS=0, reads return the pre-write value until after the edge.
//   CC: if ld_cc, cc_nzp <= {bus_in[15], bus_in==0, ~bus_in[15] & (bus_in!=0)}.
//     - cc_nzp is always exactly one-hot and is never 000.
//   BEN: if ld_ben, ben <= |(br_nzp & cc_nzp), using the CC value held BEFORE the edge.
//     - If ld_cc and ld_ben assert in the same cycle, ben uses the old CC and the new CC
//       takes effect from the next cycle.
//     - br_nzp=000 always gives ben=0; br_nzp=111 always gives ben=1.
//   Simultaneous ld_reg/ld_cc/ld_ben: all three updates are independent and all occur.
//   Arithmetic: bus_in is interpreted as two's complement; 16'h8000 sets N; 16'h0000 sets Z.
//   No X on any output after reset; dr_addr, sr1_addr and sr2_addr are always in range (3 bits).
// TESTING
//   1. Reset then read all 8 regs via sr1/sr2 -> op_a=op_b=0000; cc_nzp=010; ben=0.
//   2. Write R3=1234 with ld_cc -> next cycle op_a(sr1=3)=1234, cc_nzp=001.
//      Then write R3=8000 with ld_cc -> cc_nzp=100.
//   3. sr2mux_sel=1: imm5=10000 -> op_b=FFF0; imm5=01111 -> op_b=000F; R[sr2] is ignored.
//   4. BYPASS=1: ld_reg=1, dr=sr1=5, bus_in=ABCD -> op_a=ABCD in the same cycle.
//      BYPASS=0 -> op_a holds the old R5 until after the edge.
//   5. cc=010; ld_cc with bus_in=0001 and ld_ben with br_nzp=010 in the same cycle -> ben=1, cc=001.
//      Next ld_ben with br_nzp=010 -> ben=0.
//   6. Reset mid-stream with ld_reg=1, ld_cc=1, ld_ben=1 asserted -> all regs=0, cc=010, ben=0.

Source files
------------

// File: rtl/lc3_regfile.sv
// LC-3 register file and condition-code unit: supplies ALU operands, captures bus
// writeback into R[DR], and registers the NZP flags and branch-enable bit.
module lc3_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] sr1_addr,
    input  logic [ADDR_W-1:0] sr2_addr,
    input  logic [4:0]        imm5,
    input  logic              sr2mux_sel,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic [ADDR_W-1:0] dr_addr,
    input  logic              ld_reg,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ld_cc,
    input  logic [2:0]        br_nzp,
    input  logic              ld_ben,
    output logic [2:0]        cc_nzp,
    output logic              ben
);

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              bus_neg;
    logic              bus_zero;
    logic [2:0]        cc_next;
    logic              ben_next;

    assign imm_sext = {{(DATA_W-5){imm5[4]}}, imm5};

    // Read ports; with bypass enabled, a write in flight to the same register is forwarded.
    always_comb begin
        rd_a = regs[sr1_addr];
        rd_b = regs[sr2_addr];
        if (BYPASS != 0) begin
            if (ld_reg && (dr_addr == sr1_addr)) begin
                rd_a = bus_in;
            end
            if (ld_reg && (dr_addr == sr2_addr)) begin
                rd_b = bus_in;
            end
        end
    end

    assign op_a = rd_a;
    assign op_b = sr2mux_sel ? imm_sext : rd_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (ld_reg) begin
            regs[dr_addr] <= bus_in;
        end
    end

    assign bus_neg  = bus_in[DATA_W-1];
    assign bus_zero = (bus_in == '0);
    assign cc_next  = {bus_neg, bus_zero, ~bus_neg & ~bus_zero};

    // BEN samples the CC held before this edge, so a same-cycle ld_cc is not seen.
    assign ben_next = |(br_nzp & cc_nzp);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc_nzp <= 3'b010;
            ben    <= 1'b0;
        end else begin
            if (ld_cc) begin
                cc_nzp <= cc_next;
            end
            if (ld_ben) begin
                ben <= ben_next;
            end
        end
    end

endmodule

// File: tb/tb_lc3_regfile.sv
// Directed scoreboard bench for lc3_regfile; a BYPASS=1 and a BYPASS=0 instance
// share one stimulus stream and are compared against a behavioural model.
module tb_lc3_regfile;

    logic        clk;
    logic        rst_n;
    logic [2:0]  sr1_addr;
    logic [2:0]  sr2_addr;
    logic [4:0]  imm5;
    logic        sr2mux_sel;
    logic [2:0]  dr_addr;
    logic        ld_reg;
    logic [15:0] bus_in;
    logic        ld_cc;
    logic [2:0]  br_nzp;
    logic        ld_ben;

    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [2:0]  cc_nzp;
    logic        ben;
    logic [15:0] op_a0;
    logic [15:0] op_b0;
    logic [2:0]  cc_nzp0;
    logic        ben0;

    int checks   = 0;
    int failures = 0;

    localparam int SIG_OPA  = 0;
    localparam int SIG_OPB  = 1;
    localparam int SIG_CC   = 2;
    localparam int SIG_BEN  = 3;
    localparam int SIG_OPA0 = 4;
    localparam int SIG_OPB0 = 5;

    typedef struct {
        string       tag;
        int          sig;
        logic [15:0] val;
        bit          post;
    } exp_t;

    exp_t sb[$];

    logic [15:0] m_regs [8];
    logic [2:0]  m_cc;
    logic        m_ben;

    lc3_regfile #(.DATA_W(16), .NREG(8), .ADDR_W(3), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .sr1_addr(sr1_addr), .sr2_addr(sr2_addr),
        .imm5(imm5), .sr2mux_sel(sr2mux_sel), .op_a(op_a), .op_b(op_b),
        .dr_addr(dr_addr), .ld_reg(ld_reg), .bus_in(bus_in), .ld_cc(ld_cc),
        .br_nzp(br_nzp), .ld_ben(ld_ben), .cc_nzp(cc_nzp), .ben(ben)
    );

    lc3_regfile #(.DATA_W(16), .NREG(8), .ADDR_W(3), .BYPASS(0)) dut_nobyp (
        .clk(clk), .rst_n(rst_n), .sr1_addr(sr1_addr), .sr2_addr(sr2_addr),
        .imm5(imm5), .sr2mux_sel(sr2mux_sel), .op_a(op_a0), .op_b(op_b0),
        .dr_addr(dr_addr), .ld_reg(ld_reg), .bus_in(bus_in), .ld_cc(ld_cc),
        .br_nzp(br_nzp), .ld_ben(ld_ben), .cc_nzp(cc_nzp0), .ben(ben0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] observe(input int sig);
        case (sig)
            SIG_OPA:  return op_a;
            SIG_OPB:  return op_b;
            SIG_CC:   return {13'd0, cc_nzp};
            SIG_BEN:  return {15'd0, ben};
            SIG_OPA0: return op_a0;
            SIG_OPB0: return op_b0;
            default:  return 16'hxxxx;
        endcase
    endfunction

    function automatic void pushExp(input string tag, input int sig, input logic [15:0] val, input bit post);
        exp_t e;
        e.tag  = tag;
        e.sig  = sig;
        e.val  = val;
        e.post = post;
        sb.push_back(e);
    endfunction

    task automatic checkOutput(input bit post);
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0 && sb[0].post == post) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            checks++;
            assert (obs === e.val) else begin
                failures++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // One clock cycle: drive at negedge, check combinational reads, then registered state after the edge.
    task automatic applyStimulus(
        input string       tag,
        input logic        rst_v,
        input logic [2:0]  sr1,
        input logic [2:0]  sr2,
        input logic        mux,
        input logic [4:0]  imm,
        input logic        ldr,
        input logic [2:0]  dr,
        input logic [15:0] bus,
        input logic        ldc,
        input logic        ldb,
        input logic [2:0]  br
    );
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic [15:0] exp_b0;
        logic [2:0]  bus_cc;
        @(negedge clk);
        rst_n      = rst_v;
        sr1_addr   = sr1;
        sr2_addr   = sr2;
        sr2mux_sel = mux;
        imm5       = imm;
        ld_reg     = ldr;
        dr_addr    = dr;
        bus_in     = bus;
        ld_cc      = ldc;
        ld_ben     = ldb;
        br_nzp     = br;
        #1;

        exp_a  = (ldr && dr == sr1) ? bus : m_regs[sr1];
        exp_b  = mux ? {{11{imm[4]}}, imm} : ((ldr && dr == sr2) ? bus : m_regs[sr2]);
        exp_b0 = mux ? {{11{imm[4]}}, imm} : m_regs[sr2];
        pushExp({tag, ".op_a"},  SIG_OPA,  exp_a,        1'b0);
        pushExp({tag, ".op_b"},  SIG_OPB,  exp_b,        1'b0);
        pushExp({tag, ".op_a0"}, SIG_OPA0, m_regs[sr1],  1'b0);
        pushExp({tag, ".op_b0"}, SIG_OPB0, exp_b0,       1'b0);

        if (!rst_v) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
            m_cc  = 3'b010;
            m_ben = 1'b0;
        end else begin
            if (bus[15])           bus_cc = 3'b100;
            else if (bus == 16'h0) bus_cc = 3'b010;
            else                   bus_cc = 3'b001;
            if (ldb) m_ben = |(br & m_cc);
            if (ldc) m_cc = bus_cc;
            if (ldr) m_regs[dr] = bus;
        end
        pushExp({tag, ".cc"},        SIG_CC,   {13'd0, m_cc},  1'b1);
        pushExp({tag, ".ben"},       SIG_BEN,  {15'd0, m_ben}, 1'b1);
        pushExp({tag, ".op_a0_post"}, SIG_OPA0, m_regs[sr1],   1'b1);

        checkOutput(1'b0);
        @(posedge clk);
        #1;
        checkOutput(1'b1);
    endtask

    initial begin
        rst_n = 1'b0; sr1_addr = '0; sr2_addr = '0; sr2mux_sel = 1'b0; imm5 = '0;
        ld_reg = 1'b0; dr_addr = '0; bus_in = '0; ld_cc = 1'b0; ld_ben = 1'b0; br_nzp = '0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_cc  = 3'b010;
        m_ben = 1'b0;

        $display("[TB] reset and read-back");
        applyStimulus("reset", 1'b0, 3'd0, 3'd1, 1'b0, 5'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 8; i++) begin
            applyStimulus("rd_zero", 1'b1, 3'(i), 3'(7 - i), 1'b0, 5'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b000);
        end

        $display("[TB] writes and condition codes");
        applyStimulus("wr_r3_pos", 1'b1, 3'd3, 3'd0, 1'b0, 5'd0, 1'b1, 3'd3, 16'h1234, 1'b1, 1'b0, 3'b000);
        applyStimulus("rd_r3",     1'b1, 3'd3, 3'd3, 1'b0, 5'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b000);
        applyStimulus("wr_r3_neg", 1'b1, 3'd3, 3'd1, 1'b0, 5'd0, 1'b1, 3'd3, 16'h8000, 1'b1, 1'b0, 3'b000);

        $display("[TB] immediate operand");
        applyStimulus("imm_neg", 1'b1, 3'd0, 3'd3, 1'b1, 5'b10000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b000);
        applyStimulus("imm_pos", 1'b1, 3'd0, 3'd3, 1'b1, 5'b01111, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b000);
        applyStimulus("imm_byp", 1'b1, 3'd0, 3'd4, 1'b1, 5'b00001, 1'b1, 3'd4, 16'h4444, 1'b0, 1'b0, 3'b000);

        $display("[TB] bypass");
        applyStimulus("byp_r5",  1'b1, 3'd5, 3'd5, 1'b0, 5'd0, 1'b1, 3'd5, 16'hABCD, 1'b0, 1'b0, 3'b000);
        applyStimulus("rd_r5",   1'b1, 3'd5, 3'd4, 1'b0, 5'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b000);
        applyStimulus("wr_r0",   1'b1, 3'd1, 3'd0, 1'b0, 5'd0, 1'b1, 3'd0, 16'h7777, 1'b0, 1'b0, 3'b000);
        applyStimulus("rd_r0",   1'b1, 3'd0, 3'd5, 1'b0, 5'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b000);

        $display("[TB] branch enable");
        applyStimulus("cc_zero",   1'b1, 3'd0, 3'd0, 1'b0, 5'd0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'b000);
        applyStimulus("ben_oldcc", 1'b1, 3'd0, 3'd0, 1'b0, 5'd0, 1'b0, 3'd0, 16'h0001, 1'b1, 1'b1, 3'b010);
        applyStimulus("ben_newcc", 1'b1, 3'd0, 3'd0, 1'b0, 5'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'b010);
        applyStimulus("ben_all",   1'b1, 3'd0, 3'd0, 1'b0, 5'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'b111);
        applyStimulus("ben_none",  1'b1, 3'd0, 3'd0, 1'b0, 5'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'b000);
        applyStimulus("ben_hold",  1'b1, 3'd0, 3'd0, 1'b0, 5'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b111);

        $display("[TB] simultaneous loads");
        applyStimulus("all_loads", 1'b1, 3'd6, 3'd6, 1'b0, 5'd0, 1'b1, 3'd6, 16'hFFFF, 1'b1, 1'b1, 3'b001);
        applyStimulus("rd_r6",     1'b1, 3'd6, 3'd3, 1'b0, 5'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'b100);

        $display("[TB] reset mid-stream");
        applyStimulus("rst_mid", 1'b0, 3'd2, 3'd5, 1'b0, 5'd0, 1'b1, 3'd2, 16'h5555, 1'b1, 1'b1, 3'b111);
        for (int i = 0; i < 8; i++) begin
            applyStimulus("rd_after_rst", 1'b1, 3'(i), 3'(7 - i), 1'b0, 5'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
